alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-driven controller for the 8-bit add/sub/xor/shift datapath. Accepts one op per
//  valid/ready handshake and sequences the op on a single internal adder/shifter.
//  MUL is multi-cycle shift-and-add over that adder. The result is returned on a
//  valid/ready response port. Sits between a requester (CPU or testbench) and the arithmetic unit.
// PARAMETERS
//  WIDTH      8   operand width; results are 2*WIDTH bits wide
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  cmd_valid  in   1         command present
//  cmd_ready  out  1         controller can accept a command
//  cmd_op     in   3         000 ADD, 001 SUB, 010 XOR, 011 SHL, 100 MUL, others see CONFIG
//  cmd_a      in   WIDTH     operand A
//  cmd_b      in   WIDTH     operand B (ignored by SHL)
//  rsp_valid  out  1         response present
//  rsp_ready  in   1         consumer takes response
//  rsp_data   out  2*WIDTH   result, zero-extended unless stated otherwise
//  rsp_flag   out  1         ADD carry-out / SUB borrow / SHL bit shifted out / MUL upper-half!=0
//  rsp_err    out  1         illegal opcode
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_err=0, busy=0.
//    The ACC register (when present) is also 0.
//  - Synchronous reset mid-operation aborts the op. rsp_valid drops on the next edge and nothing is replayed.
//  - FSM: IDLE -> EXEC (single-cycle ops, illegal op) or MUL. EXEC -> DONE.
//    MUL -> DONE after WIDTH iterations. DONE -> IDLE on rsp_valid&&rsp_ready.
//  - cmd_ready=1 only in IDLE; no overlap of commands. Operands and op are latched at the handshake edge.
//  - Latency from handshake edge k: single-cycle ops assert rsp_valid after edge k+2.
//    MUL asserts it after edge k+WIDTH+2.
//  - rsp_valid/rsp_data/rsp_flag/rsp_err are held stable in DONE until rsp_ready. rsp_ready is ignored outside DONE.
//  - ADD: rsp_data = {0, cout, sum[W-1:0]}; flag = cout.
//  - SUB: rsp_data = (a-b) mod 2^W; flag = (a<b).
//  - XOR: rsp_data = a^b; flag = 0.
//  - SHL: rsp_data = (a<<1) mod 2^W; flag = a[W-1].
//  - MUL: unsigned 2W product. Each iteration: if multiplier lsb, the upper half += multiplicand via the
//    W-bit adder (carry kept). Then shift the {carry,product} pair right 1. The iteration counter runs 0..W-1.
//  - Illegal op: passes EXEC, then DONE with rsp_err=1, rsp_data=0, rsp_flag=0.
//  - cmd_valid while busy is ignored (not latched). A requester must hold it until cmd_ready.
// CONFIGURATION
//  ALU_SEQ_ACCUM_EN defined: adds a 2*WIDTH accumulator register.
//  - op 101 ACC: acc <= acc + zero-extended a, returns the new acc. flag = carry out of bit 2W-1, so acc wraps.
//  - op 110 CLR: acc <= 0, returns 0.
//  - op 111 stays illegal. Both ops take the single-cycle path.
//  ALU_SEQ_ACCUM_EN undefined: ops 101/110/111 are all illegal (rsp_err=1), and no accumulator exists.
// TESTING
//  1. ADD a=8'hFF b=8'h01 -> rsp_data=16'h0100, flag=1, rsp_valid two edges after handshake.
//  2. SUB a=8'h03 b=8'h05 -> rsp_data=16'h00FE, flag=1. SUB a=8'h05 b=8'h03 -> 16'h0002, flag=0.
//  3. MUL a=8'hFF b=8'hFF -> rsp_data=16'hFE01, flag=1, rsp_valid after edge k+10.
//     MUL a=8'h00 b=8'h7F -> 16'h0000, flag=0.
//  4. SHL a=8'h81 -> 16'h0002, flag=1.
//     Hold rsp_ready=0 for 5 cycles: outputs stable, cmd_ready=0, and a second cmd_valid is not accepted.
//  5. Start MUL, assert rst at 4th MUL cycle -> next edge all outputs at reset values.
//     A following XOR a=8'hA5 b=8'h0F -> 16'h00AA.
//  6. op=3'b111 -> rsp_err=1, data 0.
//     With ALU_SEQ_ACCUM_EN: ACC 8'h80 twice -> 16'h0080 then 16'h0100; CLR -> 16'h0000.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command-sequenced add/sub/xor/shl/mul unit sharing one WIDTH-bit adder.
// Define ALU_SEQ_ACCUM_EN to add the ACC (101) / CLR (110) accumulator ops.
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               rsp_flag,
    output logic               rsp_err,
    output logic               busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
`ifdef ALU_SEQ_ACCUM_EN
    localparam logic [2:0] OP_ACC = 3'b101;
    localparam logic [2:0] OP_CLR = 3'b110;
`endif

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

    state_t state_q;
    state_t state_n;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   prod_hi;
    logic [WIDTH-1:0]   prod_lo;
    logic [CW-1:0]      mul_cnt;
    logic               mul_primed;
    logic               rsp_valid_q;
    logic [2*WIDTH-1:0] res_data;
    logic               res_flag;
    logic               res_err;

    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic               add_ci;
    logic [WIDTH-1:0]   add_s;
    logic               add_co;

    logic [2*WIDTH-1:0] ex_data;
    logic               ex_flag;
    logic               ex_err;

    logic               cmd_fire;
    logic               mul_last;

`ifdef ALU_SEQ_ACCUM_EN
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {{(WIDTH + 1){1'b0}}, a_q};
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cmd_fire  = cmd_valid && (state_q == IDLE);
    assign mul_last  = mul_primed && (mul_cnt == CNT_LAST);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_data;
    assign rsp_flag  = res_flag;
    assign rsp_err   = res_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_n = (cmd_op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: state_n = DONE;
            MUL: begin
                if (mul_last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // One shared adder: SUB is a + ~b + 1, MUL adds the multiplicand into the upper half.
    always_comb begin
        add_x  = a_q;
        add_y  = b_q;
        add_ci = 1'b0;
        if (state_q == MUL) begin
            add_x = prod_hi;
            add_y = prod_lo[0] ? a_q : '0;
        end else if (op_q == OP_SUB) begin
            add_y  = ~b_q;
            add_ci = 1'b1;
        end
    end

    assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y}
                           + {{WIDTH{1'b0}}, add_ci};

    always_comb begin
        ex_data = '0;
        ex_flag = 1'b0;
        ex_err  = 1'b0;
        case (op_q)
            OP_ADD: begin
                ex_data = {{(WIDTH - 1){1'b0}}, add_co, add_s};
                ex_flag = add_co;
            end
            OP_SUB: begin
                ex_data = {{WIDTH{1'b0}}, add_s};
                ex_flag = ~add_co;
            end
            OP_XOR: begin
                ex_data = {{WIDTH{1'b0}}, a_q ^ b_q};
            end
            OP_SHL: begin
                ex_data = {{WIDTH{1'b0}}, a_q << 1};
                ex_flag = a_q[WIDTH-1];
            end
`ifdef ALU_SEQ_ACCUM_EN
            OP_ACC: begin
                ex_data = acc_sum[2*WIDTH-1:0];
                ex_flag = acc_sum[2*WIDTH];
            end
            OP_CLR: begin
                ex_data = '0;
            end
`endif
            default: ex_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_hi     <= '0;
            prod_lo     <= '0;
            mul_cnt     <= '0;
            mul_primed  <= 1'b0;
            rsp_valid_q <= 1'b0;
            res_data    <= '0;
            res_flag    <= 1'b0;
            res_err     <= 1'b0;
        end else begin
            if (cmd_fire) begin
                op_q       <= cmd_op;
                a_q        <= cmd_a;
                b_q        <= cmd_b;
                mul_cnt    <= '0;
                mul_primed <= 1'b0;
            end
            if (state_q == EXEC) begin
                res_data <= ex_data;
                res_flag <= ex_flag;
                res_err  <= ex_err;
            end
            // First MUL cycle loads the multiplier; WIDTH shift-add steps follow.
            if (state_q == MUL) begin
                if (!mul_primed) begin
                    prod_hi    <= '0;
                    prod_lo    <= b_q;
                    mul_primed <= 1'b1;
                end else begin
                    prod_hi <= {add_co, add_s[WIDTH-1:1]};
                    prod_lo <= {add_s[0], prod_lo[WIDTH-1:1]};
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_last) begin
                        res_data <= {add_co, add_s, prod_lo[WIDTH-1:1]};
                        res_flag <= |{add_co, add_s[WIDTH-1:1]};
                        res_err  <= 1'b0;
                    end
                end
            end
            if (state_q == DONE) begin
                if (!rsp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_SEQ_ACCUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state_q == EXEC) begin
            if (op_q == OP_ACC) begin
                acc_q <= acc_sum[2*WIDTH-1:0];
            end else if (op_q == OP_CLR) begin
                acc_q <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_op_sequencer;

    localparam int W = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic          rsp_flag;
    logic          rsp_err;
    logic          busy;

    typedef struct {
        logic [15:0] data;
        logic        flag;
        logic        err;
        int          k;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   hold_rdy = 0;
    int unsigned acc_m = 0;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_flag(rsp_flag),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [7:0] a,
                                   input logic [7:0] b);
        exp_t r;
        int unsigned s;
        r.data = 16'h0;
        r.flag = 1'b0;
        r.err  = 1'b0;
        r.k    = 0;
        r.lat  = 2;
        case (op)
            3'd0: begin
                s = a + b;
                r.data = s[15:0];
                r.flag = (s > 255);
            end
            3'd1: begin
                s = (256 + a - b) % 256;
                r.data = s[15:0];
                r.flag = (a < b);
            end
            3'd2: r.data = {8'h00, a ^ b};
            3'd3: begin
                s = (a * 2) % 256;
                r.data = s[15:0];
                r.flag = (a >= 128);
            end
            3'd4: begin
                s = a * b;
                r.data = s[15:0];
                r.flag = (s > 255);
                r.lat = W + 2;
            end
`ifdef ALU_SEQ_ACCUM_EN
            3'd5: begin
                s = acc_m + a;
                r.flag = (s > 65535);
                acc_m = s % 65536;
                r.data = acc_m[15:0];
            end
            3'd6: begin
                acc_m = 0;
                r.data = 16'h0;
            end
`endif
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        exp_t e;
        int n = 0;
        bit ok = 1;
        @(posedge clk);
        #1;
        cmd_valid = 1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 400) begin
                chk("cmd_ready_timeout", 0, 1);
                ok = 0;
                break;
            end
        end
        if (ok) begin
            e = model(op, a, b);
            e.k = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0 && !rsp_valid) break;
            n++;
            if (n > 500) begin
                chk("drain_timeout", q.size(), 0);
                q.delete();
                break;
            end
        end
    endtask

    initial begin : rdy_drv
        rsp_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        bit seen = 0;
        logic [15:0] s_data;
        logic s_flag;
        logic s_err;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = q[0];
                    if (!seen) begin
                        seen = 1;
                        s_data = rsp_data;
                        s_flag = rsp_flag;
                        s_err = rsp_err;
                        chk("latency", cyc - e.k, e.lat);
                    end else begin
                        chk("hold_data", rsp_data, s_data);
                        chk("hold_flag", rsp_flag, s_flag);
                        chk("hold_err", rsp_err, s_err);
                    end
                    if (rsp_ready) begin
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_flag", rsp_flag, e.flag);
                        chk("rsp_err", rsp_err, e.err);
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_flag"}, rsp_flag, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin : stim
        int n;
        logic [7:0] ra;
        logic [7:0] rb;
        rst = 1;
        cmd_valid = 0;
        cmd_op = 0;
        cmd_a = 0;
        cmd_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 0;

        issue(3'd0, 8'hFF, 8'h01);
        issue(3'd1, 8'h03, 8'h05);
        issue(3'd1, 8'h05, 8'h03);
        issue(3'd4, 8'hFF, 8'hFF);
        issue(3'd4, 8'h00, 8'h7F);
        drain();

        // SHL with the response held off; a competing command must not land.
        hold_rdy = 1;
        issue(3'd3, 8'h81, 8'h00);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("shl_rsp_seen", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1;
            cmd_op = 3'd0;
            cmd_a = 8'h11;
            cmd_b = 8'h22;
            @(negedge clk);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_busy", busy, 1);
            chk("hold_valid", rsp_valid, 1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 0;
        hold_rdy = 0;
        drain();
        repeat (3) @(negedge clk);
        chk("no_replay_valid", rsp_valid, 0);

        // Abort a MUL with reset during its 4th cycle.
        issue(3'd4, 8'h37, 8'h5A);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        q.delete();
        acc_m = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk_reset_vals("abort");
        repeat (12) @(negedge clk);
        chk("abort_no_rsp", rsp_valid, 0);

        issue(3'd2, 8'hA5, 8'h0F);
        issue(3'd7, 8'h12, 8'h34);
`ifdef ALU_SEQ_ACCUM_EN
        issue(3'd5, 8'h80, 8'h00);
        issue(3'd5, 8'h80, 8'h00);
        issue(3'd6, 8'h00, 8'h00);
`endif
        drain();

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 8'hFF;
            if ($urandom_range(0, 7) == 0) rb = 8'h00;
            issue(3'($urandom_range(0, 7)), ra, rb);
        end
        drain();

        @(negedge clk);
        chk("end_cmd_ready", cmd_ready, 1);
        chk("end_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
